reorder_buffer: RTL and testbench

- Circular reorder buffer for the Tomasulo core; sits between issuer, common data bus (CDB) and register file.
- Allocates a rename tag per issued instruction, captures results broadcast on the CDB, and commits in program order to the register file.
- Resolves branch mispredictions at commit by pulsing the ROB reset bus and redirecting the fetcher.

---
 rtl/reorder_buffer_pkg.sv | 16 +
 rtl/rob_ptr_inc.sv | 18 +
 rtl/reorder_buffer.sv | 160 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared sizing, types and constants for the reorder buffer
package reorder_buffer_pkg;

    localparam int ROB_DEPTH    = 15;
    localparam int ROB_ID_WIDTH = 4;
    localparam int ROB_XLEN     = 32;
    localparam int REG_ID_WIDTH = 5;

    typedef logic [ROB_ID_WIDTH-1:0] ro_buffer_id_t;
    typedef logic [REG_ID_WIDTH-1:0] reg_id_t;
    typedef logic [ROB_XLEN-1:0]     reg_t;

    // Tag 0 never names a live entry; it means "no producer".
    localparam ro_buffer_id_t ROB_TAG_NONE = '0;

endpackage

// File: rtl/rob_ptr_inc.sv
// rtl/rob_ptr_inc.sv - wrap-increment of a tag pointer over 1..DEPTH
module rob_ptr_inc #(
    parameter int DEPTH    = 15,
    parameter int ID_WIDTH = 4
) (
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] ptr_next
);

    // Skip tag 0: after the last entry the pointer goes back to 1.
    always_comb begin
        ptr_next = ptr + ID_WIDTH'(1);
        if (ptr == ID_WIDTH'(DEPTH)) begin
            ptr_next = ID_WIDTH'(1);
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer: tag allocation, CDB capture, in-order commit, mispredict flush
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH,
    parameter int ID_WIDTH = ROB_ID_WIDTH,
    parameter int XLEN     = ROB_XLEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    issue_valid,
    input  logic [REG_ID_WIDTH-1:0] issue_rd,
    input  logic                    issue_is_branch,
    input  logic                    issue_pred_taken,
    input  logic [XLEN-1:0]         issue_pc,
    output logic [ID_WIDTH-1:0]     dest_to_issuer,
    output logic                    full_to_issuer,
    input  logic                    cdb_valid,
    input  logic [ID_WIDTH-1:0]     cdb_dest,
    input  logic [XLEN-1:0]         cdb_value,
    input  logic                    cdb_taken,
    input  logic [XLEN-1:0]         cdb_target,
    output logic [ID_WIDTH-1:0]     dest_to_reg_file,
    output logic [REG_ID_WIDTH-1:0] rd_to_reg_file,
    output logic [XLEN-1:0]         value_to_reg_file,
    output logic                    reset_to_rob_bus,
    output logic [XLEN-1:0]         pc_to_fetcher
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          busy       [1:DEPTH];
    logic          ready      [1:DEPTH];
    reg_id_t       rd         [1:DEPTH];
    logic          is_branch  [1:DEPTH];
    logic          pred_taken [1:DEPTH];
    logic          taken      [1:DEPTH];
    logic [XLEN-1:0] pc       [1:DEPTH];
    logic [XLEN-1:0] value    [1:DEPTH];
    logic [XLEN-1:0] target   [1:DEPTH];

    logic [ID_WIDTH-1:0] head;
    logic [ID_WIDTH-1:0] tail;
    logic [ID_WIDTH-1:0] head_next;
    logic [ID_WIDTH-1:0] tail_next;
    logic [CW-1:0]       count;

    logic issue_accept;
    logic commit_fire;
    logic mispredict;
    logic cdb_hit;

    rob_ptr_inc #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH)) u_head_inc (
        .ptr      (head),
        .ptr_next (head_next)
    );

    rob_ptr_inc #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH)) u_tail_inc (
        .ptr      (tail),
        .ptr_next (tail_next)
    );

    // Issuer handshake and the per-cycle issue / capture / commit decisions.
    always_comb begin
        dest_to_issuer = tail;
        full_to_issuer = (count == CW'(DEPTH));
        issue_accept   = issue_valid && !full_to_issuer && rdy && !reset_to_rob_bus;
        commit_fire    = busy[head] && ready[head];
        mispredict     = commit_fire && is_branch[head] && (taken[head] != pred_taken[head]);
        cdb_hit        = 1'b0;
        if (cdb_valid && !reset_to_rob_bus && (cdb_dest != ROB_TAG_NONE)
                && (cdb_dest <= ID_WIDTH'(DEPTH))) begin
            cdb_hit = busy[cdb_dest] && !(issue_accept && (cdb_dest == tail));
        end
    end

    // Entry storage: issue writes at tail, CDB results land on their tag, commit frees head.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= DEPTH; i++) begin
                busy[i] <= 1'b0;
            end
        end else if (rdy) begin
            if (mispredict) begin
                for (int i = 1; i <= DEPTH; i++) begin
                    busy[i] <= 1'b0;
                end
            end else begin
                if (commit_fire) begin
                    busy[head] <= 1'b0;
                end
                if (cdb_hit) begin
                    ready[cdb_dest]  <= 1'b1;
                    value[cdb_dest]  <= cdb_value;
                    taken[cdb_dest]  <= cdb_taken;
                    target[cdb_dest] <= cdb_target;
                end
                if (issue_accept) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= 1'b0;
                    rd[tail]         <= issue_rd;
                    is_branch[tail]  <= issue_is_branch;
                    pred_taken[tail] <= issue_pred_taken;
                    pc[tail]         <= issue_pc;
                end
            end
        end
    end

    // Head/tail pointers and occupancy; a mispredict empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= ID_WIDTH'(1);
            tail  <= ID_WIDTH'(1);
            count <= '0;
        end else if (rdy) begin
            if (mispredict) begin
                head  <= ID_WIDTH'(1);
                tail  <= ID_WIDTH'(1);
                count <= '0;
            end else begin
                if (commit_fire) begin
                    head <= head_next;
                end
                if (issue_accept) begin
                    tail <= tail_next;
                end
                case ({issue_accept, commit_fire})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Registered commit port and flush/redirect pulse; branches never write a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dest_to_reg_file  <= '0;
            rd_to_reg_file    <= '0;
            value_to_reg_file <= '0;
            reset_to_rob_bus  <= 1'b0;
            pc_to_fetcher     <= '0;
        end else if (rdy) begin
            reset_to_rob_bus <= mispredict;
            rd_to_reg_file   <= '0;
            if (commit_fire) begin
                dest_to_reg_file  <= head;
                value_to_reg_file <= value[head];
                rd_to_reg_file    <= is_branch[head] ? '0 : rd[head];
            end
            if (mispredict) begin
                pc_to_fetcher <= taken[head] ? target[head] : pc[head] + XLEN'(4);
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer with a queue-based program-order model
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_is_branch;
    logic        issue_pred_taken;
    logic [31:0] issue_pc;
    logic [3:0]  dest_to_issuer;
    logic        full_to_issuer;
    logic        cdb_valid;
    logic [3:0]  cdb_dest;
    logic [31:0] cdb_value;
    logic        cdb_taken;
    logic [31:0] cdb_target;
    logic [3:0]  dest_to_reg_file;
    logic [4:0]  rd_to_reg_file;
    logic [31:0] value_to_reg_file;
    logic        reset_to_rob_bus;
    logic [31:0] pc_to_fetcher;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    reorder_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .issue_valid       (issue_valid),
        .issue_rd          (issue_rd),
        .issue_is_branch   (issue_is_branch),
        .issue_pred_taken  (issue_pred_taken),
        .issue_pc          (issue_pc),
        .dest_to_issuer    (dest_to_issuer),
        .full_to_issuer    (full_to_issuer),
        .cdb_valid         (cdb_valid),
        .cdb_dest          (cdb_dest),
        .cdb_value         (cdb_value),
        .cdb_taken         (cdb_taken),
        .cdb_target        (cdb_target),
        .dest_to_reg_file  (dest_to_reg_file),
        .rd_to_reg_file    (rd_to_reg_file),
        .value_to_reg_file (value_to_reg_file),
        .reset_to_rob_bus  (reset_to_rob_bus),
        .pc_to_fetcher     (pc_to_fetcher)
    );

    always #5 clk = ~clk;

    // Model: in-flight instructions in program order, plus the last committed outputs.
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        bit          br;
        bit          pred;
        bit          done;
        bit          taken;
        logic [31:0] pc;
        logic [31:0] value;
        logic [31:0] target;
    } ent_t;

    ent_t        q[$];
    int          m_tail   = 1;
    logic [4:0]  e_rd     = '0;
    int          e_dest   = 0;
    logic [31:0] e_val    = '0;
    bit          e_flush  = 1'b0;
    logic [31:0] e_pc     = '0;
    bit          e_commit = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit   full;
        bit   acc;
        bit   com;
        bit   misp;
        ent_t h;
        ent_t e;
        if (rst) begin
            q.delete();
            m_tail   = 1;
            e_rd     = '0;
            e_dest   = 0;
            e_val    = '0;
            e_flush  = 1'b0;
            e_pc     = '0;
            e_commit = 1'b0;
        end else if (rdy) begin
            full = (q.size() == 15);
            acc  = issue_valid && !full && !e_flush;
            com  = 1'b0;
            misp = 1'b0;
            if (q.size() > 0 && q[0].done) begin
                com = 1'b1;
                h   = q[0];
            end
            if (cdb_valid && !e_flush) begin
                foreach (q[i]) begin
                    if (q[i].tag == int'(cdb_dest)) begin
                        q[i].done   = 1'b1;
                        q[i].value  = cdb_value;
                        q[i].taken  = cdb_taken;
                        q[i].target = cdb_target;
                    end
                end
            end
            if (com) begin
                void'(q.pop_front());
                e_commit = 1'b1;
                e_dest   = h.tag;
                e_val    = h.value;
                e_rd     = h.br ? 5'd0 : h.rd;
                misp     = h.br && (h.taken != h.pred);
                if (misp) e_pc = h.taken ? h.target : h.pc + 32'd4;
            end else begin
                e_rd     = '0;
                e_commit = 1'b0;
            end
            e_flush = misp;
            if (misp) begin
                q.delete();
                m_tail = 1;
            end else if (acc) begin
                e.tag    = m_tail;
                e.rd     = issue_rd;
                e.br     = issue_is_branch;
                e.pred   = issue_pred_taken;
                e.done   = 1'b0;
                e.taken  = 1'b0;
                e.pc     = issue_pc;
                e.value  = '0;
                e.target = '0;
                q.push_back(e);
                m_tail = (m_tail == 15) ? 1 : m_tail + 1;
            end
        end
    endtask

    // Every cycle, away from the active edge, hold the DUT against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("m_dest_to_issuer", 32'(dest_to_issuer), 32'(m_tail));
            check("m_full", 32'(full_to_issuer), 32'(q.size() == 15));
            check("m_rd", 32'(rd_to_reg_file), 32'(e_rd));
            check("m_flush", 32'(reset_to_rob_bus), 32'(e_flush));
            if (e_commit) begin
                check("m_dest_rf", 32'(dest_to_reg_file), 32'(e_dest));
                check("m_value_rf", value_to_reg_file, e_val);
            end
            if (e_flush) check("m_pc", pc_to_fetcher, e_pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clr();
        issue_valid = 0; issue_rd = '0; issue_is_branch = 0; issue_pred_taken = 0; issue_pc = '0;
        cdb_valid = 0; cdb_dest = '0; cdb_value = '0; cdb_taken = 0; cdb_target = '0;
    endtask

    task automatic do_issue(input logic [4:0] r, input bit br, input bit pred, input logic [31:0] p);
        issue_valid = 1; issue_rd = r; issue_is_branch = br; issue_pred_taken = pred; issue_pc = p;
        tick();
        clr();
    endtask

    task automatic do_cdb(input logic [3:0] t, input logic [31:0] v, input bit tk, input logic [31:0] tg);
        cdb_valid = 1; cdb_dest = t; cdb_value = v; cdb_taken = tk; cdb_target = tg;
        tick();
        clr();
    endtask

    task automatic do_rst();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        rst = 1;
        tick();
        chk_on = 1'b1;
        tick();
        rst = 0;
        check("rst_dest_issuer", 32'(dest_to_issuer), 32'd1);
        check("rst_full", 32'(full_to_issuer), 32'd0);
        check("rst_rd", 32'(rd_to_reg_file), 32'd0);
        check("rst_dest_rf", 32'(dest_to_reg_file), 32'd0);
        check("rst_value", value_to_reg_file, 32'd0);
        check("rst_flush", 32'(reset_to_rob_bus), 32'd0);
        check("rst_pc", pc_to_fetcher, 32'd0);

        // Single issue, complete, commit.
        do_issue(5'd5, 0, 0, 32'h100);
        check("t1_dest_2", 32'(dest_to_issuer), 32'd2);
        do_cdb(4'd1, 32'h2A, 0, 32'h0);
        check("t1_rd_wait", 32'(rd_to_reg_file), 32'd0);
        tick();
        check("t1_rd", 32'(rd_to_reg_file), 32'd5);
        check("t1_dest", 32'(dest_to_reg_file), 32'd1);
        check("t1_value", value_to_reg_file, 32'h2A);
        tick();
        check("t1_rd_idle", 32'(rd_to_reg_file), 32'd0);

        // Out-of-order completion, in-order commit; stray broadcasts ignored.
        do_rst();
        do_issue(5'd3, 0, 0, 32'h10);
        do_issue(5'd4, 0, 0, 32'h14);
        do_cdb(4'd2, 32'h22, 0, 32'h0);
        check("t2_hold0", 32'(rd_to_reg_file), 32'd0);
        do_cdb(4'd0, 32'hDEAD, 0, 32'h0);
        do_cdb(4'd5, 32'hBAD, 0, 32'h0);
        check("t2_hold1", 32'(rd_to_reg_file), 32'd0);
        do_cdb(4'd1, 32'h11, 0, 32'h0);
        check("t2_hold2", 32'(rd_to_reg_file), 32'd0);
        tick();
        check("t2_c1_rd", 32'(rd_to_reg_file), 32'd3);
        check("t2_c1_val", value_to_reg_file, 32'h11);
        tick();
        check("t2_c2_rd", 32'(rd_to_reg_file), 32'd4);
        check("t2_c2_dest", 32'(dest_to_reg_file), 32'd2);
        check("t2_c2_val", value_to_reg_file, 32'h22);
        tick();

        // Fill to DEPTH, reject overflow, wrap allocation back to tag 1.
        do_rst();
        for (int i = 1; i <= 15; i++) do_issue(5'(i), 0, 0, 32'h1000 + 32'(4 * i));
        check("t3_full", 32'(full_to_issuer), 32'd1);
        check("t3_tail_wrap", 32'(dest_to_issuer), 32'd1);
        do_issue(5'd20, 0, 0, 32'h2000);
        check("t3_full_hold", 32'(full_to_issuer), 32'd1);
        do_cdb(4'd1, 32'h11, 0, 32'h0);
        tick();
        check("t3_commit_rd", 32'(rd_to_reg_file), 32'd1);
        check("t3_not_full", 32'(full_to_issuer), 32'd0);
        do_issue(5'd21, 0, 0, 32'h2004);
        check("t3_refull", 32'(full_to_issuer), 32'd1);
        check("t3_next_tag", 32'(dest_to_issuer), 32'd2);
        do_cdb(4'd2, 32'h22, 0, 32'h0);
        issue_valid = 1; issue_rd = 5'd22; issue_pc = 32'h2008;
        tick();
        clr();
        check("t3_stall_full", 32'(full_to_issuer), 32'd0);
        check("t3_stall_tag", 32'(dest_to_issuer), 32'd2);
        check("t3_stall_rd", 32'(rd_to_reg_file), 32'd2);

        // Mispredict, actually taken: flush and redirect to target.
        do_rst();
        do_issue(5'd0, 1, 0, 32'h200);
        do_issue(5'd7, 0, 0, 32'h204);
        do_cdb(4'd1, 32'h0, 1, 32'h400);
        tick();
        check("t4_flush", 32'(reset_to_rob_bus), 32'd1);
        check("t4_pc", pc_to_fetcher, 32'h400);
        check("t4_rd", 32'(rd_to_reg_file), 32'd0);
        issue_valid = 1; issue_rd = 5'd7; issue_pc = 32'h300;
        cdb_valid = 1; cdb_dest = 4'd2; cdb_value = 32'h77;
        tick();
        clr();
        check("t4_pulse_end", 32'(reset_to_rob_bus), 32'd0);
        check("t4_tag1", 32'(dest_to_issuer), 32'd1);
        check("t4_empty", 32'(full_to_issuer), 32'd0);

        // Mispredict, actually not taken: redirect to pc+4.
        do_issue(5'd0, 1, 1, 32'h300);
        do_cdb(4'd1, 32'h0, 0, 32'h999);
        tick();
        check("t4b_flush", 32'(reset_to_rob_bus), 32'd1);
        check("t4b_pc", pc_to_fetcher, 32'h304);
        tick();

        // Correctly predicted branch commits silently with no register write.
        do_rst();
        do_issue(5'd6, 1, 1, 32'h500);
        do_cdb(4'd1, 32'h55, 1, 32'h800);
        tick();
        check("t5_noflush", 32'(reset_to_rob_bus), 32'd0);
        check("t5_rd", 32'(rd_to_reg_file), 32'd0);
        check("t5_dest", 32'(dest_to_reg_file), 32'd1);
        check("t5_tag", 32'(dest_to_issuer), 32'd2);

        // rdy low freezes commit and holds registered outputs.
        do_rst();
        do_issue(5'd9, 0, 0, 32'h600);
        do_issue(5'd10, 0, 0, 32'h604);
        do_cdb(4'd1, 32'h99, 0, 32'h0);
        do_cdb(4'd2, 32'hAA, 0, 32'h0);
        check("t6_c1_rd", 32'(rd_to_reg_file), 32'd9);
        rdy = 0;
        issue_valid = 1; issue_rd = 5'd11;
        repeat (3) tick();
        clr();
        check("t6_hold_rd", 32'(rd_to_reg_file), 32'd9);
        check("t6_hold_val", value_to_reg_file, 32'h99);
        check("t6_hold_tag", 32'(dest_to_issuer), 32'd3);
        rdy = 1;
        tick();
        check("t6_c2_rd", 32'(rd_to_reg_file), 32'd10);
        check("t6_c2_val", value_to_reg_file, 32'hAA);

        // Reset with busy entries.
        do_rst();
        do_issue(5'd1, 0, 0, 32'h700);
        do_issue(5'd2, 0, 0, 32'h704);
        do_issue(5'd3, 0, 0, 32'h708);
        check("t7_tag4", 32'(dest_to_issuer), 32'd4);
        do_rst();
        check("t7_full", 32'(full_to_issuer), 32'd0);
        check("t7_tag1", 32'(dest_to_issuer), 32'd1);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
